host_cmd_loader: RTL and testbench
==================================

Name: host_cmd_loader

Overview:
- Parametrised host-command front end for the TPU top level. It decodes a 3-bit opcode plus an 8-bit data byte from the host pins.
- It streams load data into up to 4 on-chip target memories (weights, inputs, instructions, bias) using per-target auto-incrementing address pointers.
- It issues a single-cycle start pulse to the core and tracks run/done. It reads results back onto the dedicated outputs.
- It replaces the fixed one-shot fetch-flag decode with a strobe-qualified, pointer-managed, error-reporting loader.

Parameters:
- DATA_W, 8, width of host data byte and memory write data.
- ADDR_W, 4, per-target address width; depth per target = 2**ADDR_W.
- NUM_TGT, 3, number of load targets (1..4); target k is loaded by opcode k+1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- host_data  in  DATA_W  byte from host (ui_in).
- host_op  in  3  opcode from host (uio_in[7:5]).
- host_valid  in  1  host strobe (uio_in[4]), asynchronous to clk; one beat per low->high transition.
- wr_en  out  1  memory write strobe, one cycle per accepted load beat.
- wr_tgt  out  NUM_TGT  one-hot target select, valid with wr_en.
- wr_addr  out  ADDR_W  write address, valid with wr_en.
- wr_data  out  DATA_W  write data, valid with wr_en.
- start  out  1  single-cycle core start pulse.
- core_done  in  1  core completion pulse/level.
- rd_addr  out  ADDR_W  result read address.
- rd_data  in  DATA_W  result memory data, combinational from rd_addr.
- data_out  out  DATA_W  readback byte (uo_out).
- status  out  4  {err, full_any, busy, done} (uio_out[3:0]).
- status_oe  out  8  pin enables (uio_oe).

Behaviour:
- Reset (async, rst_n low) clears all of the following:
  - wr_en, start, wr_tgt, wr_addr, wr_data, rd_addr, data_out and status are 0.
  - status_oe = 8'h00.
  - All pointers, full flags and sync flops are 0; FSM = IDLE.
  - Deassertion mid-operation abandons the load/run; nothing is replayed.
- status_oe becomes 8'h0F on the first clk edge after reset release and holds.
- Strobe handling:
  - host_valid passes through a 2-flop synchroniser, then a rising-edge detect on the synchronised value.
  - The action registers on the 3rd clk edge after host_valid is first sampled high.
  - host_op/host_data are captured on that same edge. The host must hold them stable for 3 clk edges after raising host_valid.
  - Holding host_valid high produces exactly one beat.
- Opcodes (per accepted beat):
  - 0 NOP: no action.
  - 1..4 LOAD target op-1:
    - If op-1 >= NUM_TGT, or FSM = RUN, or that target is full: no write, err set.
    - Otherwise: wr_en=1 for 1 cycle, wr_tgt one-hot, wr_addr = target pointer, wr_data = byte; pointer +1.
    - Writing address 2**ADDR_W-1 sets that target's full flag. The pointer wraps to 0 but further loads are dropped until CLR_PTRS.
  - 5 START:
    - In IDLE: start=1 for exactly 1 cycle, FSM->RUN, busy=1, done=0.
    - In RUN: ignored, err set.
  - 6 CLR_PTRS: all write pointers, full flags, rd_addr and err are cleared; done is unchanged.
  - 7 READ:
    - data_out <= rd_data at the current rd_addr, then rd_addr +1 (wraps silently).
    - Allowed in IDLE only; in RUN: err set, data_out held.
- FSM states:
  - IDLE -> RUN on START.
  - RUN -> IDLE on the first cycle core_done=1; that cycle busy<=0, done<=1.
  - core_done in IDLE is ignored.
  - A beat that lands in the same cycle as core_done is evaluated against the pre-transition state (RUN).
- Status bits:
  - err is sticky until CLR_PTRS or reset.
  - full_any = OR of the full flags.
  - done is sticky until the next START.
- All outputs are registered. Nothing is combinational from host pins to outputs.

Decomposition:
- Package tpu_host_pkg holds:
  - Opcode enum (OP_NOP, OP_LOAD0..OP_LOAD3, OP_START, OP_CLR, OP_READ).
  - FSM state enum (IDLE, RUN).
  - Status bit index constants.
  - STATUS_OE constant 8'h0F.
- One sub-module: host_strobe_sync (2-flop synchroniser plus rising-edge pulse, async active-low reset). It is instantiated once.

Test Plan:
- Reset check: rst_n low mid-clock -> all outputs 0 immediately, status_oe=8'h00; then 8'h0F one edge after release.
- LOAD0 burst: op=1 with bytes 8'hA0..8'hA4 -> five wr_en pulses with wr_tgt=3'b001, addr 0..4, data A0..A4, each 3 edges after its host_valid rise. Holding host_valid high 10 cycles gives exactly one write.
- Fill boundary: 17 loads to target 1 (ADDR_W=4) -> addr 0..15 written, full_any=1 after the 16th, 17th dropped with err=1. CLR_PTRS then clears err/full and the next load writes addr 0.
- Illegal target: NUM_TGT=3, op=4 -> no wr_en, err=1.
- Run handshake:
  - START -> start high exactly 1 cycle, busy=1.
  - LOAD and READ during RUN -> rejected, err=1.
  - core_done pulse -> busy=0, done=1. A second START clears done.
- Readback: result memory model returns rd_data = 8'h30+rd_addr. Three READ beats -> data_out 30, 31, 32; rd_addr ends at 3. Wrap from 15 to 0 occurs without err.

Source files
------------

// File: rtl/tpu_host_pkg.sv
// +----------------------------------------------------------------------+
// | tpu_host_pkg: opcodes, FSM encodings and status layout for the host   |
// | command loader.                                       Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

package tpu_host_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD0 = 3'd1,
    OP_LOAD1 = 3'd2,
    OP_LOAD2 = 3'd3,
    OP_LOAD3 = 3'd4,
    OP_START = 3'd5,
    OP_CLR   = 3'd6,
    OP_READ  = 3'd7
  } host_op_e;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int STAT_DONE = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_FULL = 2;
  localparam int STAT_ERR  = 3;

  localparam logic [7:0] STATUS_OE = 8'h0F;

endpackage

`default_nettype wire

// File: rtl/host_strobe_sync.sv
// +----------------------------------------------------------------------+
// | host_strobe_sync: 2-flop synchroniser plus rising-edge pulse.         |
// |                                                       Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module host_strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign pulse = r_sync & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/host_cmd_loader.sv
// +----------------------------------------------------------------------+
// | host_cmd_loader: strobe-qualified host command decoder with per-      |
// | target load pointers, start/done tracking and result readback. Rev 1.0|
// +----------------------------------------------------------------------+
`default_nettype none

module host_cmd_loader
  import tpu_host_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int NUM_TGT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  host_data,
  input  logic [2:0]         host_op,
  input  logic               host_valid,
  output logic               wr_en,
  output logic [NUM_TGT-1:0] wr_tgt,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               start,
  input  logic               core_done,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic [DATA_W-1:0]  data_out,
  output logic [3:0]         status,
  output logic [7:0]         status_oe
);

  localparam logic [2:0] C_NUM_TGT = 3'(NUM_TGT);

  logic              w_beat;
  logic [2:0]        w_idx;
  logic              w_is_load;
  logic              w_tgt_ok;
  logic              w_sel_full;

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_ptr [NUM_TGT];
  logic [NUM_TGT-1:0] r_full;
  logic              r_err;
  logic              r_busy;
  logic              r_done;

  host_strobe_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (host_valid),
    .pulse    (w_beat)
  );

  // LOADk opcodes are k+1, so the target index is simply op-1.
  assign w_idx     = host_op - 3'd1;
  assign w_is_load = (host_op != OP_NOP) && (host_op <= OP_LOAD3);
  assign w_tgt_ok  = (w_idx < C_NUM_TGT);

  always_comb begin
    w_sel_full = 1'b0;
    for (int k = 0; k < NUM_TGT; k++) begin
      if (w_idx == 3'(k)) w_sel_full = r_full[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en     <= 1'b0;
      wr_tgt    <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      start     <= 1'b0;
      rd_addr   <= '0;
      data_out  <= '0;
      status_oe <= 8'h00;
      r_state   <= IDLE;
      r_full    <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      for (int k = 0; k < NUM_TGT; k++) r_ptr[k] <= '0;
    end else begin
      status_oe <= STATUS_OE;
      wr_en     <= 1'b0;
      start     <= 1'b0;

      if ((r_state == RUN) && core_done) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end

      // A beat is judged against the state held before this edge.
      if (w_beat) begin
        if (w_is_load) begin
          if (!w_tgt_ok || (r_state == RUN) || w_sel_full) begin
            r_err <= 1'b1;
          end else begin
            wr_en   <= 1'b1;
            wr_data <= host_data;
            wr_tgt  <= '0;
            for (int k = 0; k < NUM_TGT; k++) begin
              if (w_idx == 3'(k)) begin
                wr_tgt[k] <= 1'b1;
                wr_addr   <= r_ptr[k];
                r_ptr[k]  <= r_ptr[k] + ADDR_W'(1);
                if (r_ptr[k] == '1) r_full[k] <= 1'b1;
              end
            end
          end
        end else begin
          case (host_op)
            OP_START: begin
              if (r_state == IDLE) begin
                start   <= 1'b1;
                r_state <= RUN;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
              end else begin
                r_err <= 1'b1;
              end
            end
            OP_CLR: begin
              for (int k = 0; k < NUM_TGT; k++) r_ptr[k] <= '0;
              r_full  <= '0;
              rd_addr <= '0;
              r_err   <= 1'b0;
            end
            OP_READ: begin
              if (r_state == IDLE) begin
                data_out <= rd_data;
                rd_addr  <= rd_addr + ADDR_W'(1);
              end else begin
                r_err <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign status = {r_err, |r_full, r_busy, r_done};

endmodule

`default_nettype wire

// File: tb/tb_host_cmd_loader.sv
// Directed table-driven bench for host_cmd_loader with hand-written sequences
// for strobe hold, fill boundary, run handshake and readback wrap.
`default_nettype none

module tb_host_cmd_loader;

  logic       clk;
  logic       rst_n;
  logic [7:0] host_data;
  logic [2:0] host_op;
  logic       host_valid;
  logic       wr_en;
  logic [2:0] wr_tgt;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       core_done;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] data_out;
  logic [3:0] status;
  logic [7:0] status_oe;

  host_cmd_loader #(.DATA_W(8), .ADDR_W(4), .NUM_TGT(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host_data  (host_data),
    .host_op    (host_op),
    .host_valid (host_valid),
    .wr_en      (wr_en),
    .wr_tgt     (wr_tgt),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .core_done  (core_done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .data_out   (data_out),
    .status     (status),
    .status_oe  (status_oe)
  );

  // Result memory model
  assign rd_data = 8'h30 + {4'h0, rd_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic       dn;
    logic       en;
    logic [2:0] tgt;
    logic [3:0] addr;
    logic [7:0] wd;
    logic       st;
    logic [3:0] stat;
    logic [7:0] dout;
    logic [3:0] rda;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl [12];

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] data, input logic dn,
                              input logic en, input logic [2:0] tgt, input logic [3:0] addr,
                              input logic [7:0] wd, input logic st, input logic [3:0] stat,
                              input logic [7:0] dout, input logic [3:0] rda);
    vec_t v;
    v.op = op; v.data = data; v.dn = dn; v.en = en; v.tgt = tgt; v.addr = addr;
    v.wd = wd; v.st = st; v.stat = stat; v.dout = dout; v.rda = rda;
    return v;
  endfunction

  task automatic check_out(input string name, input vec_t v);
    n_vec++;
    if ({wr_en, wr_tgt, wr_addr, wr_data, start, status, data_out, rd_addr} !==
        {v.en, v.tgt, v.addr, v.wd, v.st, v.stat, v.dout, v.rda}) begin
      n_bad++;
      $display("FAIL %s: got en=%b tgt=%b addr=%0d wd=%h start=%b status=%b dout=%h rda=%0d; want en=%b tgt=%b addr=%0d wd=%h start=%b status=%b dout=%h rda=%0d",
               name, wr_en, wr_tgt, wr_addr, wr_data, start, status, data_out, rd_addr,
               v.en, v.tgt, v.addr, v.wd, v.st, v.stat, v.dout, v.rda);
    end
  endtask

  task automatic check_oe(input string name, input logic [7:0] exp);
    n_vec++;
    if (status_oe !== exp) begin
      n_bad++;
      $display("FAIL %s: status_oe got %h want %h", name, status_oe, exp);
    end
  endtask

  task automatic check_quiet(input string name);
    n_vec++;
    if (wr_en !== 1'b0 || start !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got wr_en=%b start=%b want 0 0", name, wr_en, start);
    end
  endtask

  // One host beat; the action must appear on exactly the 3rd edge.
  task automatic beat(input string name, input vec_t v);
    @(negedge clk);
    host_op    = v.op;
    host_data  = v.data;
    host_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_quiet({name, "_early"});
    core_done = v.dn;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    check_out(name, v);
    host_valid = 1'b0;
    @(posedge clk);
    #1;
    check_quiet({name, "_width"});
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    int at;
    logic [3:0] h_addr;
    logic [7:0] h_data;
    logic [2:0] h_tgt;

    rst_n = 1'b0; host_valid = 1'b0; core_done = 1'b0; host_op = 3'd0; host_data = 8'h00;

    //            op    data   dn  en  tgt     addr  wd     st  stat     dout   rda
    tbl[0]  = mk(3'd1, 8'hA0, 0, 1, 3'b001, 4'd0, 8'hA0, 0, 4'b0000, 8'h00, 4'd0);
    tbl[1]  = mk(3'd1, 8'hA1, 0, 1, 3'b001, 4'd1, 8'hA1, 0, 4'b0000, 8'h00, 4'd0);
    tbl[2]  = mk(3'd1, 8'hA2, 0, 1, 3'b001, 4'd2, 8'hA2, 0, 4'b0000, 8'h00, 4'd0);
    tbl[3]  = mk(3'd1, 8'hA3, 0, 1, 3'b001, 4'd3, 8'hA3, 0, 4'b0000, 8'h00, 4'd0);
    tbl[4]  = mk(3'd1, 8'hA4, 0, 1, 3'b001, 4'd4, 8'hA4, 0, 4'b0000, 8'h00, 4'd0);
    tbl[5]  = mk(3'd4, 8'h55, 0, 0, 3'b001, 4'd4, 8'hA4, 0, 4'b1000, 8'h00, 4'd0);
    tbl[6]  = mk(3'd6, 8'h00, 0, 0, 3'b001, 4'd4, 8'hA4, 0, 4'b0000, 8'h00, 4'd0);
    tbl[7]  = mk(3'd1, 8'hB0, 0, 1, 3'b001, 4'd0, 8'hB0, 0, 4'b0000, 8'h00, 4'd0);
    tbl[8]  = mk(3'd7, 8'h00, 0, 0, 3'b001, 4'd0, 8'hB0, 0, 4'b0000, 8'h30, 4'd1);
    tbl[9]  = mk(3'd7, 8'h00, 0, 0, 3'b001, 4'd0, 8'hB0, 0, 4'b0000, 8'h31, 4'd2);
    tbl[10] = mk(3'd7, 8'h00, 0, 0, 3'b001, 4'd0, 8'hB0, 0, 4'b0000, 8'h32, 4'd3);
    tbl[11] = mk(3'd0, 8'h00, 1, 0, 3'b001, 4'd0, 8'hB0, 0, 4'b0000, 8'h32, 4'd3);

    // Reset state and status_oe release
    #1;
    check_out("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check_oe("reset_oe", 8'h00);
    #21;
    rst_n = 1'b1;
    #1;
    check_oe("oe_before_edge", 8'h00);
    @(posedge clk);
    #1;
    check_oe("oe_after_edge", 8'h0F);
    repeat (3) @(posedge clk);

    for (int i = 0; i < 12; i++) beat($sformatf("tbl%0d", i), tbl[i]);

    // Holding host_valid high yields one write only
    @(negedge clk);
    host_op = 3'd1; host_data = 8'hC0; host_valid = 1'b1;
    cnt = 0; at = 0; h_addr = '0; h_data = '0; h_tgt = '0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      #1;
      if (wr_en === 1'b1) begin
        cnt++; at = i; h_addr = wr_addr; h_data = wr_data; h_tgt = wr_tgt;
      end
    end
    n_vec++;
    if (cnt != 1 || at != 3 || h_addr !== 4'd1 || h_data !== 8'hC0 || h_tgt !== 3'b001) begin
      n_bad++;
      $display("FAIL hold: got %0d writes, last at edge %0d addr=%0d data=%h tgt=%b; want 1 at edge 3 addr=1 data=c0 tgt=001",
               cnt, at, h_addr, h_data, h_tgt);
    end
    host_valid = 1'b0;
    repeat (3) @(posedge clk);

    // Fill target 1 to its boundary
    for (int i = 0; i < 16; i++)
      beat($sformatf("fill%0d", i), mk(3'd2, 8'h10 + 8'(i), 0, 1, 3'b010, 4'(i), 8'h10 + 8'(i), 0,
                                       (i == 15) ? 4'b0100 : 4'b0000, 8'h32, 4'd3));
    beat("fill_drop", mk(3'd2, 8'h99, 0, 0, 3'b010, 4'd15, 8'h1F, 0, 4'b1100, 8'h32, 4'd3));
    beat("fill_clr",  mk(3'd6, 8'h00, 0, 0, 3'b010, 4'd15, 8'h1F, 0, 4'b0000, 8'h32, 4'd0));
    beat("fill_again", mk(3'd2, 8'h77, 0, 1, 3'b010, 4'd0, 8'h77, 0, 4'b0000, 8'h32, 4'd0));

    // Run handshake
    beat("start1",    mk(3'd5, 8'h00, 0, 0, 3'b010, 4'd0, 8'h77, 1, 4'b0010, 8'h32, 4'd0));
    beat("run_load",  mk(3'd1, 8'hAA, 0, 0, 3'b010, 4'd0, 8'h77, 0, 4'b1010, 8'h32, 4'd0));
    beat("run_read",  mk(3'd7, 8'h00, 0, 0, 3'b010, 4'd0, 8'h77, 0, 4'b1010, 8'h32, 4'd0));
    beat("run_done",  mk(3'd0, 8'h00, 1, 0, 3'b010, 4'd0, 8'h77, 0, 4'b1001, 8'h32, 4'd0));
    beat("start2",    mk(3'd5, 8'h00, 0, 0, 3'b010, 4'd0, 8'h77, 1, 4'b1010, 8'h32, 4'd0));
    beat("run_clr",   mk(3'd6, 8'h00, 0, 0, 3'b010, 4'd0, 8'h77, 0, 4'b0010, 8'h32, 4'd0));
    beat("done_coincide", mk(3'd1, 8'hAB, 1, 0, 3'b010, 4'd0, 8'h77, 0, 4'b1001, 8'h32, 4'd0));
    beat("idle_clr",  mk(3'd6, 8'h00, 0, 0, 3'b010, 4'd0, 8'h77, 0, 4'b0001, 8'h32, 4'd0));

    // Readback across the address wrap
    for (int i = 0; i < 16; i++)
      beat($sformatf("read%0d", i), mk(3'd7, 8'h00, 0, 0, 3'b010, 4'd0, 8'h77, 0, 4'b0001,
                                       8'h30 + 8'(i), 4'(i + 1)));
    beat("read_wrap", mk(3'd7, 8'h00, 0, 0, 3'b010, 4'd0, 8'h77, 0, 4'b0001, 8'h30, 4'd1));
    beat("load_tgt2", mk(3'd3, 8'h5C, 0, 1, 3'b100, 4'd0, 8'h5C, 0, 4'b0001, 8'h30, 4'd1));

    // Reset asserted mid-cycle clears everything at once
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("midreset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check_oe("midreset_oe", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_oe("midreset_release_oe", 8'h0F);
    check_out("midreset_release", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
